// File: rtl/sop_vector_checker.sv
// Stimulus/response checker for a 4-input combinational block: walks all 16
// input vectors, samples the block output after a settle delay, and scores it.
module sop_vector_checker #(
    parameter logic [15:0] EXPECTED = 16'h0000,
    parameter int          SETTLE   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        OUT,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [4:0]  ERR_COUNT,
    output logic [3:0]  FIRST_FAIL,
    output logic [15:0] CAPTURED
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // With no settle time, each vector goes straight to sampling.
    localparam state_t     S_AFTER_VEC = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
    localparam logic [7:0] SETTLE_LAST = 8'((SETTLE > 0) ? (SETTLE - 1) : 0);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [7:0]  cnt;
    logic        mismatch;
    logic [4:0]  err_nxt;

    assign mismatch = (OUT != EXPECTED[idx]);
    assign err_nxt  = ERR_COUNT + {4'd0, mismatch};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_AFTER_VEC;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (idx == 4'hF) begin
                    state_nxt = S_FINISH;
                end else begin
                    state_nxt = S_AFTER_VEC;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // PASS must include the mismatch from the final sample, hence err_nxt.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx        <= 4'd0;
            cnt        <= 8'd0;
            CAPTURED   <= 16'd0;
            ERR_COUNT  <= 5'd0;
            FIRST_FAIL <= 4'd0;
            PASS       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        idx        <= 4'd0;
                        cnt        <= 8'd0;
                        CAPTURED   <= 16'd0;
                        ERR_COUNT  <= 5'd0;
                        FIRST_FAIL <= 4'd0;
                        PASS       <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    CAPTURED[idx] <= OUT;
                    if (mismatch) begin
                        ERR_COUNT <= err_nxt;
                        if (ERR_COUNT == 5'd0) begin
                            FIRST_FAIL <= idx;
                        end
                    end
                    if (idx == 4'hF) begin
                        PASS <= (err_nxt == 5'd0);
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_FINISH: begin
                    cnt <= 8'd0;
                end
                default: begin
                    cnt <= 8'd0;
                end
            endcase
        end
    end

    // Stimulus comes only from the registered index; no path from OUT.
    always_comb begin
        {A, B, C, D} = idx;
        BUSY         = (state == S_SETTLE) || (state == S_SAMPLE);
        DONE         = (state == S_FINISH);
    end

endmodule
